// File: rtl/gelu_lut_arbiter.sv
// gelu_lut_arbiter: round-robin arbiter sharing one registered GELU LUT among
// NUM_REQ int8 requesters. A tag pipeline matched to LUT_LAT steers each LUT
// result back to the requester that issued it.
// Optional build macro: GELU_ARB_STATS_EN adds per-requester grant counters
// (grant_cnt) and a LUT busy-cycle counter (busy_cnt), both saturating.
//
// Handshake: a requester transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; ready never depends on the transfer itself,
// data must stay stable while valid is high and ready is low, and the
// response is a one-cycle rsp_valid pulse with no backpressure.
module gelu_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LUT_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   lut_in_valid,
  output logic [7:0]             lut_in_data,
  input  logic                   lut_out_valid,
  input  logic [7:0]             lut_out_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   err_sticky
`ifdef GELU_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  grant_cnt,
  output logic [15:0]            busy_cnt
`endif
);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [LUT_LAT-1:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [LUT_LAT];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic               r_err;

  logic               w_gnt_any;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_idx;
  logic               w_tag_v_fin;
  logic [ID_W-1:0]    w_tag_id_fin;
  logic [NUM_REQ-1:0] w_rsp_onehot;

  // Round-robin search from r_rr_ptr; scanning offsets high-to-low lets the
  // closest asserted requester win. Nothing is granted while in reset.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    if (!rst) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (req_valid[w_idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_id  = w_idx;
        end
      end
    end
  end

  // One-hot ready and LUT drive from the selected requester.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_gnt_any && (w_gnt_id == ID_W'(i));
    end
    lut_in_valid = |(req_valid & req_ready);
    lut_in_data  = lut_in_valid ? req_data[8*w_gnt_id +: 8] : 8'd0;
  end

  // Pointer moves just past the winner on every grant, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (lut_in_valid) begin
      r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Tag pipeline: one {valid, id} stage per LUT latency cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int k = 0; k < LUT_LAT; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_v[0]  <= lut_in_valid;
      r_tag_id[0] <= w_gnt_id;
      for (int k = 1; k < LUT_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign w_tag_v_fin  = r_tag_v[LUT_LAT-1];
  assign w_tag_id_fin = r_tag_id[LUT_LAT-1];

  // Decode the final tag id into the response lane.
  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_onehot[i] = (w_tag_id_fin == ID_W'(i));
    end
  end

  // Response steering plus sticky mismatch between LUT valid and tag valid;
  // untagged results raise no response and unmatched tags are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= (lut_out_valid && w_tag_v_fin) ? w_rsp_onehot : '0;
      if (lut_out_valid) r_rsp_data <= lut_out_data;
      if (lut_out_valid != w_tag_v_fin) r_err <= 1'b1;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign err_sticky = r_err;

`ifdef GELU_ARB_STATS_EN
  logic [16*NUM_REQ-1:0] r_grant_cnt;
  logic [15:0]           r_busy_cnt;

  // Saturating per-requester handshake counters and LUT busy-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt <= '0;
      r_busy_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (r_grant_cnt[16*i +: 16] != 16'hFFFF)) begin
          r_grant_cnt[16*i +: 16] <= r_grant_cnt[16*i +: 16] + 16'd1;
        end
      end
      if (lut_in_valid && (r_busy_cnt != 16'hFFFF)) r_busy_cnt <= r_busy_cnt + 16'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign busy_cnt  = r_busy_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_gelu_lut_arbiter.sv
// Testbench for gelu_lut_arbiter (NUM_REQ=4, LUT_LAT=1). A small LUT model
// stands in for the GELU unit; it can inject a spurious valid or deliver its
// results one cycle late. Build with GELU_ARB_STATS_EN to cover the counters.
module tb_gelu_lut_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LUT_LAT = 1;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 lut_in_valid;
  logic [7:0]           lut_in_data;
  logic                 lut_out_valid;
  logic [7:0]           lut_out_data;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_data;
  logic                 err_sticky;
`ifdef GELU_ARB_STATS_EN
  logic [16*NUM_REQ-1:0] grant_cnt;
  logic [15:0]           busy_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  gelu_lut_arbiter #(.NUM_REQ(NUM_REQ), .LUT_LAT(LUT_LAT), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .lut_in_valid (lut_in_valid),
    .lut_in_data  (lut_in_data),
    .lut_out_valid(lut_out_valid),
    .lut_out_data (lut_out_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .err_sticky   (err_sticky)
`ifdef GELU_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt),
    .busy_cnt     (busy_cnt)
`endif
  );

  // Coarse GELU stand-in: identity for x>=0, x>>>3 for x<0.
  function automatic logic [7:0] lut_fn(input logic [7:0] x);
    return x[7] ? {{3{1'b1}}, x[7:3]} : x;
  endfunction

  // LUT model: two register stages; normal results come from stage 0,
  // lut_slow selects stage 1, inj forces a spurious valid.
  logic [1:0] m_v = 2'b00;
  logic [7:0] m_d0 = 8'h00;
  logic [7:0] m_d1 = 8'h00;
  logic       inj = 1'b0;
  logic       lut_slow = 1'b0;

  always @(posedge clk) begin
    m_v  <= {m_v[0], lut_in_valid};
    m_d0 <= lut_fn(lut_in_data);
    m_d1 <= m_d0;
  end

  assign lut_out_valid = inj | (lut_slow ? m_v[1] : m_v[0]);
  assign lut_out_data  = inj ? 8'h55 : (lut_slow ? m_d1 : m_d0);

  // Hand-computed vectors
  localparam logic [7:0] SS_DIN [3] = '{8'h80, 8'h00, 8'h7F};
  localparam logic [7:0] SS_EXP [3] = '{8'hF0, 8'h00, 8'h7F};
  localparam logic [7:0] RR_EXP [4] = '{8'h05, 8'hFF, 8'h40, 8'hF8};
  localparam logic [3:0] WR_VALID [5] = '{4'b0100, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
  localparam logic [3:0] WR_READY [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
  localparam logic [3:0] WR_RSP   [5] = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001};
  localparam logic [7:0] WR_D     [5] = '{8'h00, 8'h00, 8'h22, 8'h33, 8'h01};

  // Driver: one-cycle reset pulse, leaves the bench just after a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; inj = 1'b0; lut_slow = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_data = 32'hC040F805;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    n_checks++; if (lut_in_valid !== 1'b0) begin n_errors++; $display("FAIL reset_lut_in_valid got %b exp 0", lut_in_valid); end
    n_checks++; if (lut_in_data !== 8'h00) begin n_errors++; $display("FAIL reset_lut_in_data got %h exp 00", lut_in_data); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", err_sticky); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
    n_checks++; if (lut_in_data !== 8'h05) begin n_errors++; $display("FAIL reset_first_data got %h exp 05", lut_in_data); end
    req_valid = '0;
  endtask

  task automatic test_single_stream();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 3) begin
        req_valid = 4'b0010; req_data = {16'h0000, SS_DIN[c], 8'h00};
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      n_checks++;
      if (req_ready !== ((c < 3) ? 4'b0010 : 4'b0000)) begin
        n_errors++; $display("FAIL ss_ready c=%0d got %b", c, req_ready);
      end
      if (c < 3) begin
        n_checks++;
        if (lut_in_data !== SS_DIN[c]) begin n_errors++; $display("FAIL ss_lut_in c=%0d got %h exp %h", c, lut_in_data, SS_DIN[c]); end
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (rsp_valid !== 4'b0010) begin n_errors++; $display("FAIL ss_rsp_valid c=%0d got %b exp 0010", c, rsp_valid); end
        n_checks++;
        if (rsp_data !== SS_EXP[c-2]) begin n_errors++; $display("FAIL ss_rsp_data c=%0d got %h exp %h", c, rsp_data, SS_EXP[c-2]); end
      end else begin
        n_checks++;
        if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL ss_rsp_idle c=%0d got %b exp 0000", c, rsp_valid); end
      end
    end
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL ss_err got %b exp 0", err_sticky); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    do_reset();
    req_data = {8'hC0, 8'h40, 8'hF8, 8'h05};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_oh = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_checks++;
      if (req_ready !== exp_oh) begin n_errors++; $display("FAIL rr_ready c=%0d got %b exp %b", c, req_ready, exp_oh); end
      exp_oh = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
      n_checks++;
      if (rsp_valid !== exp_oh) begin n_errors++; $display("FAIL rr_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_oh); end
      if (c >= 2) begin
        n_checks++;
        if (rsp_data !== RR_EXP[(c-2)%4]) begin n_errors++; $display("FAIL rr_rsp_data c=%0d got %h exp %h", c, rsp_data, RR_EXP[(c-2)%4]); end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_data = {8'h33, 8'h22, 8'h00, 8'h01};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = WR_VALID[c];
      #1;
      n_checks++;
      if (req_ready !== WR_READY[c]) begin n_errors++; $display("FAIL wrap_ready c=%0d got %b exp %b", c, req_ready, WR_READY[c]); end
      n_checks++;
      if (rsp_valid !== WR_RSP[c]) begin n_errors++; $display("FAIL wrap_rsp_valid c=%0d got %b exp %b", c, rsp_valid, WR_RSP[c]); end
      if (WR_RSP[c] != 4'b0000) begin
        n_checks++;
        if (rsp_data !== WR_D[c]) begin n_errors++; $display("FAIL wrap_rsp_data c=%0d got %h exp %h", c, rsp_data, WR_D[c]); end
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk); #1;
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL sp_err_before got %b exp 0", err_sticky); end
    @(negedge clk); inj = 1'b1;
    @(negedge clk); inj = 1'b0; #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL sp_rsp_valid got %b exp 0000", rsp_valid); end
    n_checks++; if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL sp_err_set got %b exp 1", err_sticky); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL sp_err_held got %b exp 1", err_sticky); end
    do_reset();
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL sp_err_cleared got %b exp 0", err_sticky); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    lut_slow = 1'b1;
    req_data = {8'h00, 8'h22, 8'h11, 8'h00};
    @(negedge clk); req_valid = 4'b0010; #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL rf_ready0 got %b exp 0010", req_ready); end
    @(negedge clk); req_valid = 4'b0100; #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL rf_ready1 got %b exp 0100", req_ready); end
    @(negedge clk); req_valid = 4'b0001; rst = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL rf_ready_in_rst got %b exp 0000", req_ready); end
    n_checks++; if (lut_in_valid !== 1'b0) begin n_errors++; $display("FAIL rf_lut_in_rst got %b exp 0", lut_in_valid); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL rf_rsp_a got %b exp 0000", rsp_valid); end
    @(negedge clk); req_valid = 4'b0000; rst = 1'b0; #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL rf_rsp_b got %b exp 0000", rsp_valid); end
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL rf_err_after_rst got %b exp 0", err_sticky); end
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL rf_rsp_c got %b exp 0000", rsp_valid); end
    n_checks++; if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL rf_err_late got %b exp 1", err_sticky); end
    req_valid = 4'b1111; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rf_ptr_zero got %b exp 0001", req_ready); end
    req_valid = 4'b0000;
    lut_slow = 1'b0;
  endtask

`ifdef GELU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req_valid = 4'b0001;
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (grant_cnt[15:0] !== 16'd5) begin n_errors++; $display("FAIL st_grant5 got %h exp 0005", grant_cnt[15:0]); end
    n_checks++; if (busy_cnt !== 16'd5) begin n_errors++; $display("FAIL st_busy5 got %h exp 0005", busy_cnt); end
    repeat (69995) @(negedge clk);
    #1;
    req_valid = 4'b0000;
    n_checks++; if (grant_cnt[15:0] !== 16'hFFFF) begin n_errors++; $display("FAIL st_grant_sat got %h exp ffff", grant_cnt[15:0]); end
    n_checks++; if (busy_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL st_busy_sat got %h exp ffff", busy_cnt); end
    n_checks++; if (grant_cnt[31:16] !== 16'h0000) begin n_errors++; $display("FAIL st_grant1 got %h exp 0000", grant_cnt[31:16]); end
  endtask
`endif

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  // Test sequence and final report
  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_wrap();
    test_spurious();
    test_reset_inflight();
`ifdef GELU_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gelu_lut_arbiter.md
Name: gelu_lut_arbiter

Overview:
- Round-robin arbiter that shares one GELU LUT activation unit among NUM_REQ independent int8 requesters.
- The LUT unit is a single-cycle registered lookup with valid-in/valid-out and no backpressure.
- This block grants at most one requester per cycle and drives the LUT input.
- It tracks in-flight requester IDs in a latency-matched tag pipeline and steers each LUT result back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LUT_LAT, 1, cycles from lut_in_valid to lut_out_valid of the attached LUT (1..4).
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester input valid.
- req_data  input  8*NUM_REQ  signed int8 operands; requester i occupies bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- lut_in_valid  output  1  drive to the LUT's in_valid.
- lut_in_data  output  8  drive to the LUT's in_data.
- lut_out_valid  input  1  from the LUT's out_valid.
- lut_out_data  input  8  from the LUT's out_data.
- rsp_valid  output  NUM_REQ  one-hot result valid; pulses for one cycle.
- rsp_data  output  8  result value, shared by all requesters; qualified by rsp_valid.
- err_sticky  output  1  protocol-mismatch flag.

Behaviour:
- Reset, synchronous with rst high: rr_ptr=0, tag pipeline cleared, rsp_valid=0, rsp_data=0, err_sticky=0.
- req_ready and lut_in_* are combinational and therefore 0 while rst is asserted.
- Arbitration, combinational:
  - Search req_valid starting at index rr_ptr and wrap modulo NUM_REQ.
  - The first asserted index g receives req_ready[g]=1; all other ready bits are 0.
  - req_ready is 0 for all requesters when no req_valid is asserted.
- LUT drive, combinational: lut_in_valid = |(req_valid & req_ready); lut_in_data = req_data slice of g, or 0 when idle.
- Pointer update, registered: on a grant, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- A requester holding req_valid high is served within NUM_REQ cycles. There is no starvation.
- Tag pipeline:
  - LUT_LAT stages of {v, id}.
  - Stage0 <= {lut_in_valid, g}; stage k <= stage k-1.
  - The final stage is aligned with lut_out_valid.
- Response, registered, one cycle after lut_out_valid:
  - rsp_valid <= onehot(tag_final.id) & {NUM_REQ{lut_out_valid}}.
  - rsp_data <= lut_out_data when lut_out_valid is high; otherwise rsp_data holds.
- Total latency from the req handshake to rsp_valid is LUT_LAT+1 cycles. Throughput is one operation per cycle across all requesters.
- Error detection:
  - If lut_out_valid != tag_final.v in any cycle, err_sticky <= 1. It clears only on rst.
  - If lut_out_valid=1 while tag_final.v=0, no rsp_valid is raised.
  - If tag_final.v=1 while lut_out_valid=0, the tag is dropped.
- Requesters must hold req_data stable while req_valid is high and ready is low. The block does not check this.
- Reset mid-operation: in-flight tags are discarded. LUT results arriving after rst deassertion with no tag set err_sticky, per the rule above.

Optional Feature:
- Macro GELU_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, width 16*NUM_REQ: one saturating 16-bit counter per requester, incremented on each of its handshakes, cleared by rst, stuck at 16'hFFFF when saturated.
  - Adds output busy_cnt, 16 bits: counts cycles with lut_in_valid=1, saturating.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single requester 1 streams req_data = -128, 0, 127 back-to-back (LUT_LAT=1, LUT model = reference table). Required: req_ready[1] high every cycle; rsp_valid[1] pulses at cycles +2, +3, +4 with table[-128], table[0], table[127]; err_sticky=0.
- All 4 requesters valid continuously for 8 cycles from rr_ptr=0. Required: grant order 0,1,2,3,0,1,2,3; each rsp_valid returns to the matching index with that requester's data.
- Requester 2 only for 1 cycle, then requesters 0 and 3 together. Required: grants 2, then 3, then 0 (wrap-around from ptr=3).
- LUT model injects a spurious lut_out_valid with no prior grant. Required: no rsp_valid; err_sticky=1 next cycle and held until rst.
- rst pulsed while 2 ops are in flight. Required: rsp_valid stays 0 and rr_ptr=0 afterward; the late LUT outputs set err_sticky.
- With GELU_ARB_STATS_EN, 70000 grants to requester 0. Required: grant_cnt[15:0]=16'hFFFF and busy_cnt=16'hFFFF.
